// File: rtl/prog_counter_mode.sv
// prog_counter_mode: WIDTH-bit up/down counter with a programmable terminal
// value and four end-of-count modes (wrap, saturate, one-shot, auto-reload).
// It drives a pad-ready output bus (data plus per-bit output enable), a
// one-cycle terminal-count pulse and a sticky one-shot done flag.
// Optional compare output: define COUNTER_CMP_EN to add cmp_val/match.
module prog_counter_mode #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             oe,
`ifdef COUNTER_CMP_EN
    input  logic [WIDTH-1:0] cmp_val,
    output logic             match,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] y_oe,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] LP_RESET = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] LP_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] LP_ZERO  = '0;

    localparam logic [1:0] MODE_WRAP   = 2'd0;
    localparam logic [1:0] MODE_SAT    = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'd3;

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_done;

    logic [WIDTH-1:0] w_q_next;
    logic             w_tc_next;
    logic             w_done_next;
    logic             w_at_term;

    // Terminal test: up-counting uses >= so a value loaded above limit is
    // already terminal; down-counting terminates at zero.
    always_comb begin
        w_at_term = 1'b0;
        if (up) begin
            w_at_term = (r_q >= limit);
        end else begin
            w_at_term = (r_q == LP_ZERO);
        end
    end

    // Next-state: load beats counting; a completed one-shot freezes the count.
    always_comb begin
        w_q_next    = r_q;
        w_tc_next   = 1'b0;
        w_done_next = r_done;
        if (load) begin
            w_q_next    = load_val;
            w_done_next = 1'b0;
        end else if (en && !r_done) begin
            if (!w_at_term) begin
                w_q_next = up ? (r_q + LP_ONE) : (r_q - LP_ONE);
            end else begin
                w_tc_next = 1'b1;
                case (mode)
                    MODE_WRAP:    w_q_next = up ? LP_ZERO : limit;
                    MODE_SAT:     w_q_next = r_q;
                    MODE_ONESHOT: w_done_next = 1'b1;
                    MODE_RELOAD:  w_q_next = load_val;
                    default:      w_q_next = r_q;
                endcase
            end
        end
    end

    // Count, terminal pulse and done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= LP_RESET;
            r_tc   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_tc   <= w_tc_next;
            r_done <= w_done_next;
        end
    end

`ifdef COUNTER_CMP_EN
    logic r_match;

    // Compare against the value q is about to take, so match lines up with q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else begin
            r_match <= (w_q_next == cmp_val);
        end
    end

    assign match = r_match;
`endif

    assign q     = r_q;
    assign y_out = r_q;
    assign y_oe  = {WIDTH{oe}};
    assign tc    = r_tc;
    assign done  = r_done;

endmodule

// File: doc/prog_counter_mode.md
Name: prog_counter_mode

Overview:
- Parametrised successor to the 8-bit programmable counter: WIDTH-bit up/down counter with programmable terminal value (limit) and four end-of-count modes.
- Modes: wrap, saturate, one-shot, auto-reload.
- Provides a tri-state-ready output bus (data plus per-bit OE) and a continuous count mirror, for direct use behind the bidirectional pad wrapper.
- Adds a terminal-count pulse and a sticky done flag for timer and period-generator use.

Parameters:
- WIDTH, 8: counter, load, limit and output width in bits (legal range 2..32).
- RESET_VAL, 0: value of q after reset (must be less than 2^WIDTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable.
- load  in  1  synchronous load of load_val; has priority over counting.
- load_val  in  WIDTH  load / reload value.
- up  in  1  direction: 1 = increment, 0 = decrement.
- mode  in  2  end-of-count mode: 0 wrap, 1 saturate, 2 one-shot, 3 auto-reload.
- limit  in  WIDTH  terminal value for up-counting; wrap target for down-counting.
- oe  in  1  output drive enable.
- q  out  WIDTH  current count, always valid (mirror).
- y_out  out  WIDTH  equals q (pad data).
- y_oe  out  WIDTH  all bits equal oe (pad drive enables; 1 = drive).
- tc  out  1  terminal-count pulse, one cycle wide.
- done  out  1  sticky one-shot completion flag.

Behaviour:
- Reset (rst_n low, asynchronous): q=RESET_VAL, tc=0, done=0. y_oe follows oe combinationally, so it is not affected by reset.
- Per-cycle priority: load > (en and not done) > hold.
- Load:
  - q <= load_val, done <= 0, tc <= 0.
  - load with en=1 in the same cycle: load wins, no count that cycle.
- "At terminal":
  - up=1: q >= limit. Using >= means a q loaded above limit is also terminal.
  - up=0: q == 0.
- Count step when en=1, load=0, done=0, not at terminal: q <= q+1 (up) or q-1 (down).
- Count step at terminal (en=1, load=0, done=0), by mode:
  - 0 wrap: up gives q<=0; down gives q<=limit.
  - 1 saturate: q holds.
  - 2 one-shot: q holds, done<=1. Counting stops until the next load or reset, even if up changes.
  - 3 auto-reload: q <= load_val, for either direction.
- tc:
  - Registered: tc <= 1 in the cycle after any count step taken at terminal, in every mode.
  - Saturate mode repeats tc on every enabled cycle while held at terminal.
  - In all other cases tc <= 0.
- done:
  - Set only in mode 2. Cleared only by load or reset.
  - Changing mode while done=1 does not clear done.
- en=0: q, done hold; tc <= 0.
- Arithmetic is modulo 2^WIDTH. limit=0 with up=1 makes every enabled cycle a terminal event.
- mode, up and limit are sampled every cycle. A change takes effect on the next edge, with no pipeline.
- Latency: q updates one edge after inputs are sampled. y_out/y_oe are combinational from q/oe, no extra delay.

Optional Feature:
- Macro COUNTER_CMP_EN.
- Defined:
  - Adds input cmp_val (WIDTH) and output match (1).
  - match is registered: match <= (next value of q == cmp_val).
  - match is therefore high in the same cycle q equals cmp_val.
  - match is 0 in reset; it is also evaluated on load.
- Undefined:
  - Ports cmp_val and match do not exist.
  - No comparator logic is generated.

Test Plan (WIDTH=8):
- Reset mid-count: count to 5, pull rst_n low between edges -> q=0, tc=0, done=0 immediately, without a clock edge.
- Wrap up: mode=0, up=1, limit=9, en=1 from q=0 -> q sequence 0..9,0; tc high exactly the cycle after 9 -> 0. Same setup with up=0 from q=0 -> q=9, tc pulse.
- Saturate and priority:
  - mode=1, limit=3, counting up -> q holds 3, tc high every enabled cycle.
  - Assert load with load_val=0x80 and en=1 -> q=0x80 next cycle, no increment.
- One-shot: mode=2, up=0, load 4 -> q 4,3,2,1,0 then done=1, q stays 0 with en=1. Load 2 -> done=0, counting resumes.
- Auto-reload and bus:
  - mode=3, load_val=2, limit=5, up=1 -> q 2..5,2,3...; tc every 4th enabled cycle.
  - Toggling oe -> y_oe switches between 0x00 and 0xFF combinationally; y_out always equals q.
- With COUNTER_CMP_EN: cmp_val=7, counting up from 0 -> match high only while q=7. Load 7 -> match high the next cycle.
